// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: FSM state codes and access length codes.
package mem_port_arbiter_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_IF_RD  = 3'd1;
    localparam logic [2:0] ST_MEM_RD = 3'd2;
    localparam logic [2:0] ST_MEM_WR = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd3;

    // Length code 2 (three bytes) is not a legal access size and is widened to a word.
    function automatic logic [1:0] norm_len(input logic [1:0] len);
        case (len)
            LEN_B, LEN_H: norm_len = len;
            default:      norm_len = LEN_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte burst sequencer: walks the RAM address, drives write bytes and assembles
// little-endian read data for one granted access.
module mem_byte_seq
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [1:0]        start_len,
    input  logic              start_we,
    input  logic [DATA_W-1:0] start_wdata,
    input  logic              rd_active,
    input  logic              wr_active,
    input  logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_wr,
    output logic [DATA_W-1:0] word_next,
    output logic              last_beat
);

    logic [2:0]        cnt;
    logic [1:0]        last_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] word_q;
    logic [1:0]        byte_idx;

    // In a read, the byte arriving now belongs to the address issued one count earlier.
    assign byte_idx = cnt[1:0] - 2'd1;

    always_comb begin
        word_next = word_q | (DATA_W'(ram_dout) << {byte_idx, 3'b000});
        last_beat = 1'b0;
        if (rd_active)
            last_beat = (cnt == ({1'b0, last_q} + 3'd1));
        else if (wr_active)
            last_beat = (cnt == {1'b0, last_q});

        ram_addr = '0;
        ram_din  = 8'h00;
        ram_wr   = 1'b0;
        // Byte 0 goes out in the grant cycle straight from the request inputs.
        if (start) begin
            ram_addr = start_addr;
            ram_wr   = start_we;
            ram_din  = start_we ? start_wdata[7:0] : 8'h00;
        end else if (rd_active || wr_active) begin
            ram_addr = base_q + ADDR_W'(cnt);
            if (wr_active) begin
                ram_wr  = 1'b1;
                ram_din = wdata_q[{cnt[1:0], 3'b000} +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= 3'd0;
        else if (start)
            cnt <= 3'd1;
        else if (rd_active || wr_active)
            cnt <= cnt + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (start) begin
            base_q  <= start_addr;
            last_q  <= start_len;
            wdata_q <= start_wdata;
            word_q  <= '0;
        end else if (rd_active) begin
            word_q  <= word_next;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the byte-wide RAM port between instruction fetch and the data stage,
// with MEM priority, byte bursts and per-stage stall requests.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              stallreq_if,
    output logic              stallreq_mem,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_dout,
    output logic [7:0]        ram_din,
    output logic              ram_wr
);

    logic [2:0]        state;
    logic [1:0]        mem_len_n;
    logic              grant_mem;
    logic              grant_if;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [1:0]        start_len;
    logic              start_we;
    logic              rd_active;
    logic              wr_active;
    logic [DATA_W-1:0] word_next;
    logic              last_beat;

    assign mem_len_n = norm_len(mem_len);

    // Grants are held off while rst is high so nothing reaches the RAM during reset.
    always_comb begin
        grant_mem  = (state == ST_IDLE) && !rst && mem_req;
        grant_if   = (state == ST_IDLE) && !rst && !mem_req && if_req;
        start      = grant_mem || grant_if;
        start_addr = grant_mem ? mem_addr : if_addr;
        start_len  = grant_mem ? mem_len_n : LEN_W;
        start_we   = grant_mem && mem_we;
        rd_active  = (state == ST_IF_RD) || (state == ST_MEM_RD);
        wr_active  = (state == ST_MEM_WR);
    end

    mem_byte_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_addr  (start_addr),
        .start_len   (start_len),
        .start_we    (start_we),
        .start_wdata (mem_wdata),
        .rd_active   (rd_active),
        .wr_active   (wr_active),
        .ram_dout    (ram_dout),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_wr      (ram_wr),
        .word_next   (word_next),
        .last_beat   (last_beat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_data   <= '0;
            mem_rdata <= '0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_mem) begin
                        // A single-byte store completes entirely in the grant cycle.
                        if (mem_we && (mem_len_n == LEN_B)) begin
                            state    <= ST_DONE;
                            mem_done <= 1'b1;
                        end else begin
                            state <= mem_we ? ST_MEM_WR : ST_MEM_RD;
                        end
                    end else if (grant_if) begin
                        state <= ST_IF_RD;
                    end
                end
                ST_IF_RD: begin
                    if (!if_req) begin
                        state <= ST_IDLE;
                    end else if (last_beat) begin
                        state   <= ST_DONE;
                        if_done <= 1'b1;
                        if_data <= word_next;
                    end
                end
                ST_MEM_RD: begin
                    if (last_beat) begin
                        state     <= ST_DONE;
                        mem_done  <= 1'b1;
                        mem_rdata <= word_next;
                    end
                end
                ST_MEM_WR: begin
                    if (last_beat) begin
                        state    <= ST_DONE;
                        mem_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stallreq_mem = mem_req & ~mem_done;
    assign stallreq_if  = if_req & ~if_done;

    // The data stage may not withdraw a request before its completion pulse.
    a_mem_req_held: assert property (@(posedge clk) disable iff (rst)
        (mem_req && !mem_done) |=> (mem_req || mem_done));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural byte RAM.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_data;
    logic              if_done;
    logic              mem_req = 1'b0;
    logic              mem_we = 1'b0;
    logic [1:0]        mem_len = 2'd0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [DATA_W-1:0] mem_wdata = '0;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              stallreq_if;
    logic              stallreq_mem;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_dout = 8'h00;
    logic [7:0]        ram_din;
    logic              ram_wr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_data      (if_data),
        .if_done      (if_done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_len      (mem_len),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem),
        .ram_addr     (ram_addr),
        .ram_dout     (ram_dout),
        .ram_din      (ram_din),
        .ram_wr       (ram_wr)
    );

    logic [7:0] ram_mem [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        ram_dout <= ram_mem[ram_addr];
        if (ram_wr) ram_mem[ram_addr] <= ram_din;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_if;
        logic [31:0] data;
        int          cyc;
    } done_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        din;
        int                cyc;
    } wr_t;

    done_t dq[$];
    wr_t   wq[$];
    done_t d_item;
    wr_t   w_item;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT completes an access or strobes a write.
    always @(negedge clk) begin
        if (if_done || mem_done) begin
            if (dq.size() == 0) begin
                check("unexpected_done", {30'b0, if_done, mem_done}, 32'h0);
            end else begin
                d_item = dq.pop_front();
                check("done_kind", 32'(if_done), 32'(d_item.is_if));
                check("done_cycle", 32'(cyc), 32'(d_item.cyc));
                check("done_data", d_item.is_if ? if_data : mem_rdata, d_item.data);
            end
        end
        if (ram_wr) begin
            if (wq.size() == 0) begin
                check("unexpected_ram_wr", 32'(ram_addr), 32'hFFFF_FFFF);
            end else begin
                w_item = wq.pop_front();
                check("wr_addr", 32'(ram_addr), 32'(w_item.addr));
                check("wr_din", 32'(ram_din), 32'(w_item.din));
                check("wr_cycle", 32'(cyc), 32'(w_item.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input logic want_if, input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            #1;
            seen = want_if ? if_done : mem_done;
        end
        check(want_if ? "if_done_seen" : "mem_done_seen", 32'(seen), 32'd1);
        if (want_if) if_req = 1'b0;
        else         mem_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_data"}, if_data, 32'h0);
        check({tag, "_if_done"}, 32'(if_done), 32'h0);
        check({tag, "_mem_rdata"}, mem_rdata, 32'h0);
        check({tag, "_mem_done"}, 32'(mem_done), 32'h0);
        check({tag, "_stallreq_if"}, 32'(stallreq_if), 32'h0);
        check({tag, "_stallreq_mem"}, 32'(stallreq_mem), 32'h0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
        check({tag, "_ram_din"}, 32'(ram_din), 32'h0);
        check({tag, "_ram_wr"}, 32'(ram_wr), 32'h0);
    endtask

    task automatic mem_issue(input logic we, input logic [1:0] len,
                             input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
        mem_we    = we;
        mem_len   = len;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_req   = 1'b1;
    endtask

    int a;

    initial begin
        ram_mem[17'h00010] = 8'h10; ram_mem[17'h00011] = 8'h11;
        ram_mem[17'h00012] = 8'h12; ram_mem[17'h00013] = 8'h13;
        ram_mem[17'h00020] = 8'h44; ram_mem[17'h00021] = 8'h33;
        ram_mem[17'h00022] = 8'h22; ram_mem[17'h00023] = 8'h11;
        ram_mem[17'h1FFFF] = 8'hA1; ram_mem[17'h00000] = 8'hB2;
        ram_mem[17'h00001] = 8'hC3; ram_mem[17'h00002] = 8'hD4;

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        tick();

        // IF word read, little-endian assembly
        a = cyc;
        if_addr = 17'h00010;
        if_req  = 1'b1;
        dq.push_back('{1'b1, 32'h13121110, a + 5});
        #1;
        check("stallreq_if_busy", 32'(stallreq_if), 32'd1);
        wait_done(1'b1, 20);
        tick();
        check("if_data_hold", if_data, 32'h13121110);

        // MEM byte write
        a = cyc;
        mem_issue(1'b1, 2'd0, 17'h00100, 32'h000000AB);
        wq.push_back('{17'h00100, 8'hAB, a});
        dq.push_back('{1'b0, 32'h0, a + 1});
        wait_done(1'b0, 20);
        tick();

        // MEM half write
        a = cyc;
        mem_issue(1'b1, 2'd1, 17'h00100, 32'h0000BEEF);
        wq.push_back('{17'h00100, 8'hEF, a});
        wq.push_back('{17'h00101, 8'hBE, a + 1});
        dq.push_back('{1'b0, 32'h0, a + 2});
        wait_done(1'b0, 20);
        tick();

        // MEM write with length code 2 behaves as a word
        a = cyc;
        mem_issue(1'b1, 2'd2, 17'h00200, 32'h11223344);
        wq.push_back('{17'h00200, 8'h44, a});
        wq.push_back('{17'h00201, 8'h33, a + 1});
        wq.push_back('{17'h00202, 8'h22, a + 2});
        wq.push_back('{17'h00203, 8'h11, a + 3});
        dq.push_back('{1'b0, 32'h0, a + 4});
        wait_done(1'b0, 20);
        tick();

        // MEM half read of the bytes just written, upper half zero
        a = cyc;
        mem_issue(1'b0, 2'd1, 17'h00100, 32'h0);
        dq.push_back('{1'b0, 32'h0000BEEF, a + 3});
        wait_done(1'b0, 20);
        tick();

        // Simultaneous requests: MEM word read wrapping the address space, then IF
        a = cyc;
        if_addr = 17'h00020;
        if_req  = 1'b1;
        mem_issue(1'b0, 2'd3, 17'h1FFFF, 32'h0);
        dq.push_back('{1'b0, 32'hD4C3B2A1, a + 5});
        dq.push_back('{1'b1, 32'h11223344, a + 11});
        #1;
        check("both_stallreq_if", 32'(stallreq_if), 32'd1);
        check("both_stallreq_mem", 32'(stallreq_mem), 32'd1);
        wait_done(1'b0, 20);
        check("stallreq_if_waiting", 32'(stallreq_if), 32'd1);
        wait_done(1'b1, 20);
        tick();

        // IF fetch withdrawn mid-burst, pending MEM read granted right after
        a = cyc;
        if_addr = 17'h00040;
        if_req  = 1'b1;
        tick();
        mem_issue(1'b0, 2'd0, 17'h00010, 32'h0);
        #1;
        check("stallreq_mem_behind_if", 32'(stallreq_mem), 32'd1);
        tick();
        if_req = 1'b0;
        dq.push_back('{1'b0, 32'h00000010, a + 5});
        wait_done(1'b0, 20);
        tick();
        check("if_data_after_abort", if_data, 32'h11223344);

        // Reset in the middle of a word write
        a = cyc;
        mem_issue(1'b1, 2'd3, 17'h00300, 32'hCAFEF00D);
        wq.push_back('{17'h00300, 8'h0D, a});
        wq.push_back('{17'h00301, 8'hF0, a + 1});
        tick();
        rst     = 1'b1;
        mem_req = 1'b0;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        tick();

        // Fresh fetch after reset
        a = cyc;
        if_addr = 17'h00010;
        if_req  = 1'b1;
        dq.push_back('{1'b1, 32'h13121110, a + 5});
        wait_done(1'b1, 20);
        repeat (4) tick();

        check("done_queue_empty", 32'(dq.size()), 32'd0);
        check("wr_queue_empty", 32'(wq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
